// File: rtl/x_flashsm_mc_pkg.sv
// Shared definitions for the multi-channel LED flash generator.
//  - state_t : per-channel FSM encoding (value 3 is unused and recovers to IDLE)
//  - DEF_*   : default timing constants for a 40 MHz clock
package x_flashsm_mc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    HWAIT = 2'd2
  } state_t;

  localparam int DEF_NCH    = 8;
  localparam int DEF_PRE    = 13;  // tick every 2^13 clocks
  localparam int DEF_CW     = 6;   // flash = 2^6 ticks = 13.1 ms @ 40 MHz
  localparam int DEF_BLK    = 10;  // blink half-period 2^22 clocks
  localparam int DEF_RETRIG = 1;
  localparam int DEF_INVERT = 0;

endpackage

// File: rtl/x_flashsm_mc_if.sv
// LED control bundle between a status source and the flash generator.
//  trigger/hold/blink : per-channel requests
//  lamp_test          : force all LEDs on
//  out                : per-channel LED drive
//  active             : any channel busy
interface x_flashsm_mc_if #(
  parameter int NCH = 8
);
  logic [NCH-1:0] trigger;
  logic [NCH-1:0] hold;
  logic [NCH-1:0] blink;
  logic           lamp_test;
  logic [NCH-1:0] out;
  logic           active;

  modport master (
    output trigger, hold, blink, lamp_test,
    input  out, active
  );

  modport slave (
    input  trigger, hold, blink, lamp_test,
    output out, active
  );
endinterface

// File: rtl/x_flashsm_mc_chan.sv
// One LED channel: flash FSM, tick counter and registered LED drive.
//  clock, reset_n    : system clock, synchronous active-low reset
//  tick, blink_phase : shared prescaler strobes from the top
//  trig, hold, blink, lt : registered per-channel controls / lamp test
//  out_q             : registered LED drive (already polarity-adjusted)
//  busy              : state != IDLE (combinational from the state flop)
module x_flashsm_mc_chan
  import x_flashsm_mc_pkg::*;
#(
  parameter int CW     = DEF_CW,
  parameter int RETRIG = DEF_RETRIG,
  parameter int INVERT = DEF_INVERT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tick,
  input  logic blink_phase,
  input  logic trig,
  input  logic hold,
  input  logic blink,
  input  logic lt,
  output logic out_q,
  output logic busy
);
  localparam logic INV = (INVERT != 0);
  localparam logic RT  = (RETRIG != 0);

  state_t        st;
  logic [CW-1:0] cnt;
  logic          on_w;

  // Blinking only blanks the LED in HWAIT, during the low half of the blink phase.
  assign on_w = (st != IDLE) && !((st == HWAIT) && blink && !blink_phase);
  assign busy = (st != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st    <= IDLE;
      cnt   <= '0;
      out_q <= INV;
    end else begin
      out_q <= (on_w | lt) ^ INV;
      case (st)
        IDLE: begin
          cnt <= '0;
          if (trig) st <= FLASH;
        end
        FLASH: begin
          // Retrigger wins over the terminal count in the same cycle.
          if (RT && trig) begin
            cnt <= '0;
          end else if (tick && (cnt == '1)) begin
            st  <= HWAIT;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(tick);
          end
        end
        HWAIT: begin
          cnt <= '0;
          if (!hold) st <= IDLE;
        end
        default: begin
          st  <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: rtl/x_flashsm_mc.sv
// Multi-channel LED flash pulse generator.
//  clock   : system clock
//  reset_n : synchronous active-low reset
//  bus     : slave side of x_flashsm_mc_if (trigger/hold/blink/lamp_test in,
//            out/active out)
// One free-running prescaler is shared by all channels; its low PRE bits give
// the flash tick and its MSB gives the blink phase.
module x_flashsm_mc
  import x_flashsm_mc_pkg::*;
#(
  parameter int NCH    = DEF_NCH,
  parameter int PRE    = DEF_PRE,
  parameter int CW     = DEF_CW,
  parameter int BLK    = DEF_BLK,
  parameter int RETRIG = DEF_RETRIG,
  parameter int INVERT = DEF_INVERT
) (
  input  logic               clock,
  input  logic               reset_n,
  x_flashsm_mc_if.slave      bus
);
  localparam int PW = PRE + BLK;

  logic [PW-1:0]  pre;
  logic [NCH-1:0] trig_ff, hold_ff, blink_ff;
  logic           lt_ff;
  logic           active_q;
  logic [NCH-1:0] out_w, busy_w;
  logic           tick, blink_phase;

  assign tick        = (pre[PRE-1:0] == '1);
  assign blink_phase = pre[PW-1];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pre      <= '0;
      trig_ff  <= '0;
      hold_ff  <= '0;
      blink_ff <= '0;
      lt_ff    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      pre      <= pre + 1'b1;
      trig_ff  <= bus.trigger;
      // A live trigger also counts as hold so a held trigger parks in HWAIT.
      hold_ff  <= bus.hold | bus.trigger;
      blink_ff <= bus.blink;
      lt_ff    <= bus.lamp_test;
      active_q <= |busy_w;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    x_flashsm_mc_chan #(
      .CW(CW), .RETRIG(RETRIG), .INVERT(INVERT)
    ) u_ch (
      .clock      (clock),
      .reset_n    (reset_n),
      .tick       (tick),
      .blink_phase(blink_phase),
      .trig       (trig_ff[i]),
      .hold       (hold_ff[i]),
      .blink      (blink_ff[i]),
      .lt         (lt_ff),
      .out_q      (out_w[i]),
      .busy       (busy_w[i])
    );
  end

  assign bus.out    = out_w;
  assign bus.active = active_q;
endmodule
